// File: rtl/nonce_range_sequencer_if.sv
// rtl/nonce_range_sequencer_if.sv - job, core-broadcast and result signal bundle for nonce_range_sequencer
//
// Purpose: groups every non-clock signal of the sequencer.
//   slave  modport: the sequencer itself.
//   master modport: the job source / core array / result consumer side.
// Signal summary:
//   job_*    : job handshake (valid/ready) plus midstate, data, inclusive nonce range, abort
//   core_*   : registered broadcast to the hash cores, NUM_CORES nonce lanes with per-lane valid
//   golden_* : per-core hit pulses and their nonces
//   res_*    : result FIFO head (valid/ready), nonce and originating core index
//   busy, job_done, overflow : status
interface nonce_range_sequencer_if #(
  parameter int NUM_CORES = 4
);
  localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic                      job_valid;
  logic                      job_ready;
  logic [255:0]              job_midstate;
  logic [95:0]               job_data;
  logic [31:0]               job_nonce_min;
  logic [31:0]               job_nonce_max;
  logic                      job_abort;
  logic [255:0]              core_midstate;
  logic [95:0]               core_data;
  logic [NUM_CORES*32-1:0]   core_nonce;
  logic [NUM_CORES-1:0]      core_valid;
  logic [NUM_CORES-1:0]      golden_valid;
  logic [NUM_CORES*32-1:0]   golden_nonce;
  logic                      res_valid;
  logic [31:0]               res_nonce;
  logic [CW-1:0]             res_core;
  logic                      res_ready;
  logic                      busy;
  logic                      job_done;
  logic                      overflow;

  modport slave (
    input  job_valid, job_midstate, job_data, job_nonce_min, job_nonce_max, job_abort,
    input  golden_valid, golden_nonce, res_ready,
    output job_ready, core_midstate, core_data, core_nonce, core_valid,
    output res_valid, res_nonce, res_core, busy, job_done, overflow
  );

  modport master (
    output job_valid, job_midstate, job_data, job_nonce_min, job_nonce_max, job_abort,
    output golden_valid, golden_nonce, res_ready,
    input  job_ready, core_midstate, core_data, core_nonce, core_valid,
    input  res_valid, res_nonce, res_core, busy, job_done, overflow
  );
endinterface

// File: rtl/nonce_range_sequencer.sv
// rtl/nonce_range_sequencer.sv - nonce range sweeper and golden-nonce collector for NUM_CORES hash cores
//
// Purpose: accepts a job, issues NUM_CORES consecutive nonces per issue cycle across an
// inclusive (wrapping) range, drains the core pipeline, and funnels per-core hits through
// holding registers and a round-robin arbiter into a result FIFO.
// Ports:
//   hash_clk : sole clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : nonce_range_sequencer_if.slave (job, core broadcast, hits, results, status)
module nonce_range_sequencer #(
  parameter int NUM_CORES    = 4,
  parameter int LOOP_LOG2    = 0,
  parameter int PIPE_LATENCY = 130,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          hash_clk,
  input  logic                          reset_n,
  nonce_range_sequencer_if.slave        bus
);
  localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int PW = (LOOP_LOG2 > 0) ? LOOP_LOG2 : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = 10;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                  r_state;
  logic [31:0]             r_base;
  logic [32:0]             r_remaining;
  logic [PW-1:0]           r_phase;
  logic [DW-1:0]           r_drain_cnt;
  logic [255:0]            r_midstate;
  logic [95:0]             r_data;
  logic [NUM_CORES*32-1:0] r_core_nonce;
  logic [NUM_CORES-1:0]    r_core_valid;
  logic                    r_job_done;
  logic                    r_overflow;
  logic [NUM_CORES-1:0]    r_hold_full;
  logic [31:0]             r_hold_nonce [NUM_CORES];
  logic [CW-1:0]           r_last_grant;
  logic [31:0]             r_fifo_nonce [FIFO_DEPTH];
  logic [CW-1:0]           r_fifo_core  [FIFO_DEPTH];
  logic [AW-1:0]           r_wr_ptr;
  logic [AW-1:0]           r_rd_ptr;
  logic [AW:0]             r_count;
  logic [31:0]             r_res_nonce;
  logic [CW-1:0]           r_res_core;

  logic                    w_active;
  logic                    w_load;
  logic                    w_abort;
  logic                    w_issue_tick;
  logic [32:0]             w_load_remaining;
  logic [31:0]             w_issue_base;
  logic [32:0]             w_issue_remaining;
  logic [32:0]             w_issue_take;
  logic [32:0]             w_rem_after;
  logic [NUM_CORES*32-1:0] w_issue_nonce;
  logic [NUM_CORES-1:0]    w_issue_valid;
  logic [NUM_CORES-1:0]    w_req;
  logic                    w_grant_any;
  logic [CW-1:0]           w_grant_idx;
  int                      w_scan_idx;
  logic [NUM_CORES-1:0]    w_grant_vec;
  logic                    w_pop;
  logic                    w_push;
  logic [31:0]             w_push_nonce;
  logic [AW:0]             w_count_next;
  logic [AW-1:0]           w_rd_next;

  assign w_active         = (r_state != S_IDLE);
  assign w_load           = (r_state == S_IDLE) && bus.job_valid;
  assign w_abort          = w_active && bus.job_abort;
  // Phase counter free-runs in RUN and wraps at 2^LOOP_LOG2, so the all-ones value marks the issue slot.
  assign w_issue_tick     = (LOOP_LOG2 == 0) || (&r_phase);
  // Range size is max-min+1 modulo 2^32, widened so max = min-1 yields the full 2^32 sweep.
  assign w_load_remaining = {1'b0, bus.job_nonce_max - bus.job_nonce_min} + 33'd1;

  always_comb begin
    w_issue_base      = w_load ? bus.job_nonce_min : r_base;
    w_issue_remaining = w_load ? w_load_remaining : r_remaining;
    w_issue_take      = (w_issue_remaining > 33'(NUM_CORES)) ? 33'(NUM_CORES) : w_issue_remaining;
    w_rem_after       = w_issue_remaining - w_issue_take;
    w_issue_nonce     = '0;
    w_issue_valid     = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_issue_nonce[32*i +: 32] = w_issue_base + 32'(i);
      w_issue_valid[i]          = (w_issue_remaining > 33'(i));
    end
  end

  // A fresh hit on an empty holding register competes directly, so it can reach the FIFO the same cycle.
  always_comb begin
    w_req       = r_hold_full | (w_active ? bus.golden_valid : '0);
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    w_scan_idx  = 0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      w_scan_idx = (int'(r_last_grant) + k) % NUM_CORES;
      if (!w_grant_any && w_req[w_scan_idx]) begin
        w_grant_any = 1'b1;
        w_grant_idx = CW'(w_scan_idx);
      end
    end
  end

  assign w_pop        = (r_count != '0) && bus.res_ready;
  assign w_push       = w_grant_any && ((r_count != (AW+1)'(FIFO_DEPTH)) || w_pop);
  assign w_push_nonce = r_hold_full[w_grant_idx] ? r_hold_nonce[w_grant_idx]
                                                 : bus.golden_nonce[32*w_grant_idx +: 32];

  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      w_grant_vec[i] = w_push && (w_grant_idx == CW'(i));
    end
  end

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - 1'b1;
    end
    w_rd_next = w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
  end

  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_base       <= '0;
      r_remaining  <= '0;
      r_phase      <= '0;
      r_drain_cnt  <= '0;
      r_midstate   <= '0;
      r_data       <= '0;
      r_core_nonce <= '0;
      r_core_valid <= '0;
      r_job_done   <= 1'b0;
    end else begin
      r_job_done   <= 1'b0;
      r_core_valid <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_load) begin
            r_midstate   <= bus.job_midstate;
            r_data       <= bus.job_data;
            r_phase      <= '0;
            r_core_nonce <= w_issue_nonce;
            r_core_valid <= w_issue_valid;
            r_base       <= w_issue_base + 32'(NUM_CORES);
            r_remaining  <= w_rem_after;
            r_drain_cnt  <= DW'(PIPE_LATENCY);
            r_state      <= (w_rem_after == '0) ? S_DRAIN : S_RUN;
          end
        end
        S_RUN: begin
          if (w_abort) begin
            r_state <= S_IDLE;
          end else begin
            r_phase <= r_phase + 1'b1;
            if (w_issue_tick) begin
              r_core_nonce <= w_issue_nonce;
              r_core_valid <= w_issue_valid;
              r_base       <= w_issue_base + 32'(NUM_CORES);
              r_remaining  <= w_rem_after;
              if (w_rem_after == '0) begin
                r_state <= S_DRAIN;
              end
            end
          end
        end
        S_DRAIN: begin
          if (w_abort) begin
            r_state <= S_IDLE;
          end else if (r_drain_cnt != '0) begin
            r_drain_cnt <= r_drain_cnt - 1'b1;
          end else if ((r_hold_full == '0) && (bus.golden_valid == '0)) begin
            r_job_done <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A holding register that is full drops any new hit (overflow), even when it is granted this cycle.
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hold_full  <= '0;
      r_overflow   <= 1'b0;
      r_last_grant <= CW'(NUM_CORES - 1);
    end else begin
      if (w_push) begin
        r_last_grant <= w_grant_idx;
      end
      if (w_load) begin
        r_overflow <= 1'b0;
      end
      for (int i = 0; i < NUM_CORES; i++) begin
        if (w_abort) begin
          r_hold_full[i] <= 1'b0;
        end else if (w_active && bus.golden_valid[i] && r_hold_full[i]) begin
          r_overflow <= 1'b1;
          if (w_grant_vec[i]) begin
            r_hold_full[i] <= 1'b0;
          end
        end else if (w_active && bus.golden_valid[i] && !w_grant_vec[i]) begin
          r_hold_full[i] <= 1'b1;
        end else if (w_grant_vec[i]) begin
          r_hold_full[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge hash_clk) begin
    for (int i = 0; i < NUM_CORES; i++) begin
      if (w_active && bus.golden_valid[i] && !r_hold_full[i]) begin
        r_hold_nonce[i] <= bus.golden_nonce[32*i +: 32];
      end
    end
    if (w_push) begin
      r_fifo_nonce[r_wr_ptr] <= w_push_nonce;
      r_fifo_core[r_wr_ptr]  <= w_grant_idx;
    end
  end

  // The FIFO head is kept in its own register so res_nonce holds the last value once the FIFO empties.
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_res_nonce <= '0;
      r_res_core  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      r_rd_ptr <= w_rd_next;
      r_count  <= w_count_next;
      if (w_count_next != '0) begin
        if (w_push && (w_rd_next == r_wr_ptr)) begin
          r_res_nonce <= w_push_nonce;
          r_res_core  <= w_grant_idx;
        end else begin
          r_res_nonce <= r_fifo_nonce[w_rd_next];
          r_res_core  <= r_fifo_core[w_rd_next];
        end
      end
    end
  end

  assign bus.job_ready     = (r_state == S_IDLE);
  assign bus.busy          = (r_state != S_IDLE);
  assign bus.core_midstate = r_midstate;
  assign bus.core_data     = r_data;
  assign bus.core_nonce    = r_core_nonce;
  assign bus.core_valid    = r_core_valid;
  assign bus.res_valid     = (r_count != '0);
  assign bus.res_nonce     = r_res_nonce;
  assign bus.res_core      = r_res_core;
  assign bus.job_done      = r_job_done;
  assign bus.overflow      = r_overflow;
endmodule

// File: tb/tb_nonce_range_sequencer.sv
// tb/tb_nonce_range_sequencer.sv - directed self-checking bench for nonce_range_sequencer
module tb_nonce_range_sequencer;
  logic hash_clk = 1'b0;
  logic reset_n  = 1'b0;
  always #5 hash_clk = ~hash_clk;

  nonce_range_sequencer_if #(.NUM_CORES(4)) bus  ();
  nonce_range_sequencer_if #(.NUM_CORES(4)) bus2 ();

  nonce_range_sequencer #(
    .NUM_CORES(4), .LOOP_LOG2(0), .PIPE_LATENCY(8), .FIFO_DEPTH(2)
  ) u_dut (
    .hash_clk(hash_clk), .reset_n(reset_n), .bus(bus)
  );

  nonce_range_sequencer #(
    .NUM_CORES(4), .LOOP_LOG2(2), .PIPE_LATENCY(8), .FIFO_DEPTH(2)
  ) u_dut_l2 (
    .hash_clk(hash_clk), .reset_n(reset_n), .bus(bus2)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;

  always @(posedge hash_clk) begin
    if (bus.job_done === 1'b1) n_done++;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge hash_clk);
    #1;
  endtask

  task automatic load_job(input logic [31:0] mn, input logic [31:0] mx);
    bus.job_valid     = 1'b1;
    bus.job_nonce_min = mn;
    bus.job_nonce_max = mx;
    tick();
    bus.job_valid     = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int lat);
    lat = 0;
    while (bus.job_done !== 1'b1 && lat < limit) begin
      tick();
      lat++;
    end
  endtask

  int          lat;
  int          done_before;
  logic [11:0] pat;
  logic [31:0] n_c2;
  logic [31:0] n_c9;

  initial begin
    bus.job_valid = 0; bus.job_midstate = 256'h0123_4567_89AB_CDEF; bus.job_data = 96'hCAFE_F00D;
    bus.job_nonce_min = 0; bus.job_nonce_max = 0; bus.job_abort = 0;
    bus.golden_valid = 0; bus.golden_nonce = 0; bus.res_ready = 0;
    bus2.job_valid = 0; bus2.job_midstate = 0; bus2.job_data = 0;
    bus2.job_nonce_min = 0; bus2.job_nonce_max = 0; bus2.job_abort = 0;
    bus2.golden_valid = 0; bus2.golden_nonce = 0; bus2.res_ready = 0;

    // Reset state
    tick();
    check("rst_job_ready", bus.job_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_core_valid", bus.core_valid, 0);
    check("rst_overflow", bus.overflow, 0);
    reset_n = 1'b1;
    tick();

    // Partial batch: 7 nonces
    load_job(32'h1DAC2B7A, 32'h1DAC2B80);
    check("b1_nonce", bus.core_nonce, {32'h1DAC2B7D, 32'h1DAC2B7C, 32'h1DAC2B7B, 32'h1DAC2B7A});
    check("b1_valid", bus.core_valid, 4'b1111);
    check("b1_busy", bus.busy, 1);
    check("b1_job_ready", bus.job_ready, 0);
    check("b1_midstate", bus.core_midstate, 128'h0123_4567_89AB_CDEF);
    tick();
    check("b2_nonce", bus.core_nonce, {32'h1DAC2B81, 32'h1DAC2B80, 32'h1DAC2B7F, 32'h1DAC2B7E});
    check("b2_valid", bus.core_valid, 4'b0111);
    tick();
    check("drain_valid", bus.core_valid, 0);
    check("drain_nonce_hold", bus.core_nonce[31:0], 32'h1DAC2B7E);
    wait_done(20, lat);
    check("done_latency", lat + 1, 9);
    check("done_idle", bus.job_ready, 1);
    tick();
    check("done_pulse", bus.job_done, 0);

    // Genesis hit on core 2, 8 cycles after batch 1
    load_job(32'h1DAC2B7A, 32'h1DAC2B80);
    repeat (8) tick();
    check("gen_pre_valid", bus.res_valid, 0);
    bus.golden_valid = 4'b0100;
    bus.golden_nonce = {32'h0, 32'h1DAC2B7C, 32'h0, 32'h0};
    tick();
    bus.golden_valid = 4'b0000;
    check("gen_res_valid", bus.res_valid, 1);
    check("gen_res_nonce", bus.res_nonce, 32'h1DAC2B7C);
    check("gen_res_core", bus.res_core, 2);
    wait_done(20, lat);
    check("gen_done", bus.job_done, 1);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("gen_popped", bus.res_valid, 0);
    check("gen_nonce_hold", bus.res_nonce, 32'h1DAC2B7C);

    // Asynchronous reset in the middle of a job
    load_job(32'h0, 32'hFFFFFFFF);
    tick();
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_job_ready", bus.job_ready, 1);
    check("arst_core_valid", bus.core_valid, 0);
    tick();
    reset_n = 1'b1;
    tick();

    // Simultaneous hits with backpressure
    load_job(32'h0, 32'hFFFFFFFF);
    tick();
    bus.golden_valid = 4'b1011;
    bus.golden_nonce = {32'h103, 32'h0, 32'h101, 32'h100};
    tick();
    bus.golden_valid = 4'b0000;
    check("sim_head0_valid", bus.res_valid, 1);
    check("sim_head0_nonce", bus.res_nonce, 32'h100);
    check("sim_head0_core", bus.res_core, 0);
    tick();
    check("sim_full_nonce", bus.res_nonce, 32'h100);
    bus.golden_valid = 4'b1000;
    bus.golden_nonce = {32'h203, 32'h0, 32'h0, 32'h0};
    tick();
    bus.golden_valid = 4'b0000;
    check("sim_overflow", bus.overflow, 1);
    check("sim_stall_nonce", bus.res_nonce, 32'h100);
    bus.res_ready = 1'b1;
    tick();
    check("sim_head1_nonce", bus.res_nonce, 32'h101);
    check("sim_head1_core", bus.res_core, 1);
    tick();
    check("sim_head3_nonce", bus.res_nonce, 32'h103);
    check("sim_head3_core", bus.res_core, 3);
    tick();
    check("sim_empty", bus.res_valid, 0);
    bus.res_ready = 1'b0;
    done_before = n_done;
    bus.job_abort = 1'b1;
    tick();
    bus.job_abort = 1'b0;
    check("sim_abort_busy", bus.busy, 0);
    repeat (20) tick();
    check("sim_abort_no_done", n_done, done_before);
    check("sim_overflow_sticky", bus.overflow, 1);

    // Wrap through 0xFFFFFFFF
    load_job(32'hFFFFFFFE, 32'h00000001);
    check("wrap_nonce", bus.core_nonce, {32'h1, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFE});
    check("wrap_valid", bus.core_valid, 4'b1111);
    check("wrap_ovf_clear", bus.overflow, 0);
    wait_done(20, lat);
    check("wrap_done_latency", lat, 9);

    // Full 2^32 range, aborted after 100 issues
    load_job(32'h5, 32'h4);
    repeat (99) tick();
    check("full_nonce0", bus.core_nonce[31:0], 32'h191);
    check("full_nonce3", bus.core_nonce[127:96], 32'h194);
    check("full_valid", bus.core_valid, 4'b1111);
    done_before = n_done;
    bus.job_abort = 1'b1;
    tick();
    bus.job_abort = 1'b0;
    check("full_abort_busy", bus.busy, 0);
    check("full_abort_valid", bus.core_valid, 0);
    check("full_abort_ready", bus.job_ready, 1);
    repeat (20) tick();
    check("full_abort_no_done", n_done, done_before);

    // LOOP_LOG2=2: 12 nonces, one issue every 4 cycles
    bus2.job_valid     = 1'b1;
    bus2.job_nonce_min = 32'h10;
    bus2.job_nonce_max = 32'h1B;
    tick();
    bus2.job_valid     = 1'b0;
    pat  = '0;
    n_c2 = '0;
    n_c9 = '0;
    for (int k = 0; k < 12; k++) begin
      pat[k] = |bus2.core_valid;
      if (k == 1) n_c2 = bus2.core_nonce[31:0];
      if (k == 8) n_c9 = bus2.core_nonce[31:0];
      tick();
    end
    check("l2_pattern", pat, 12'h111);
    check("l2_nonce_hold", n_c2, 32'h10);
    check("l2_third_batch", n_c9, 32'h18);
    lat = 0;
    while (bus2.job_done !== 1'b1 && lat < 30) begin
      tick();
      lat++;
    end
    check("l2_done_latency", lat, 5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
